// File: rtl/hazard_sequencer.sv
// Pipeline hazard sequencer: Moore FSM that freezes or flushes the front end
// for taken branches, load-use hazards and multi-cycle multiplies.
module hazard_sequencer #(
  parameter int unsigned MULT_LAT = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        branch_taken,
  input  logic        mult_req,
  input  logic        load_use,
  input  logic        stall_clr,
  output logic        en_B1,
  output logic        en_M2,
  output logic        en_H3,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        mult_busy,
  output logic        mult_done,
  output logic [7:0]  mult_cnt,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FLUSH   = 2'd1,
    LDSTALL = 2'd2,
    MULT    = 2'd3
  } state_t;

  localparam logic [7:0]  MULT_LOAD = 8'(MULT_LAT - 1);
  localparam logic [15:0] STALL_MAX = 16'hFFFF;

  state_t      state_q, state_d;
  logic [7:0]  mult_cnt_q, mult_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // NOTE: reset is synchronous, so it lives inside the clocked branch and
  // overrides every next-state value, including a concurrent stall_clr.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mult_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mult_cnt_q  <= mult_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Next state; lower-priority events are dropped, upstream re-presents them.
  // NOTE: every comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    mult_cnt_d = mult_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (branch_taken) begin
          state_d = FLUSH;
        end else if (mult_req) begin
          state_d    = MULT;
          mult_cnt_d = MULT_LOAD;
        end else if (load_use) begin
          state_d = LDSTALL;
        end
      end
      FLUSH, LDSTALL: state_d = IDLE;
      MULT: begin
        if (mult_cnt_q == 8'd0) begin
          state_d = IDLE;
        end else begin
          mult_cnt_d = mult_cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Moore output decode: a function of state (and the state-held counter) only.
  always_comb begin
    en_B1      = 1'b0;
    en_M2      = 1'b0;
    en_H3      = 1'b0;
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    mult_busy  = 1'b0;
    mult_done  = 1'b0;
    unique case (state_q)
      IDLE: ;
      FLUSH: begin
        en_B1      = 1'b1;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end
      LDSTALL: begin
        en_H3      = 1'b1;
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        idex_flush = 1'b1;
      end
      MULT: begin
        en_M2      = 1'b1;
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        idex_flush = 1'b1;
        mult_busy  = 1'b1;
        mult_done  = (mult_cnt_q == 8'd0);
      end
      default: ;
    endcase
  end

  // Stall performance counter: clear beats increment, and it never wraps.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_clr) begin
      stall_cnt_d = '0;
    end else if (!pc_write && (stall_cnt_q != STALL_MAX)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  assign mult_cnt  = mult_cnt_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer: a MULT_LAT=4 instance for sequencing
// and a MULT_LAT=255 instance to reach stall counter saturation quickly.
module tb_hazard_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Control vector order: en_B1 en_M2 en_H3 pc_write ifid_write ifid_flush idex_flush mult_busy mult_done
  localparam logic [8:0] V_IDLE  = 9'b000_11_00_0_0;
  localparam logic [8:0] V_FLUSH = 9'b100_11_11_0_0;
  localparam logic [8:0] V_LDST  = 9'b001_00_01_0_0;
  localparam logic [8:0] V_MULT  = 9'b010_00_01_1_0;
  localparam logic [8:0] V_MDONE = 9'b010_00_01_1_1;

  logic branch_taken = 1'b0, mult_req = 1'b0, load_use = 1'b0, stall_clr = 1'b0;
  logic en_B1, en_M2, en_H3, pc_write, ifid_write, ifid_flush, idex_flush, mult_busy, mult_done;
  logic [7:0]  mult_cnt;
  logic [15:0] stall_cnt;
  logic [8:0]  ctrl;

  logic b_branch_taken = 1'b0, b_mult_req = 1'b0, b_load_use = 1'b0, b_stall_clr = 1'b0;
  logic b_en_B1, b_en_M2, b_en_H3, b_pc_write, b_ifid_write, b_ifid_flush, b_idex_flush;
  logic b_mult_busy, b_mult_done;
  logic [7:0]  b_mult_cnt;
  logic [15:0] b_stall_cnt;
  logic [8:0]  b_ctrl;

  hazard_sequencer #(.MULT_LAT(4)) dut (
    .clk(clk), .rst(rst), .branch_taken(branch_taken), .mult_req(mult_req),
    .load_use(load_use), .stall_clr(stall_clr), .en_B1(en_B1), .en_M2(en_M2),
    .en_H3(en_H3), .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .mult_busy(mult_busy),
    .mult_done(mult_done), .mult_cnt(mult_cnt), .stall_cnt(stall_cnt)
  );

  hazard_sequencer #(.MULT_LAT(255)) dut_b (
    .clk(clk), .rst(rst), .branch_taken(b_branch_taken), .mult_req(b_mult_req),
    .load_use(b_load_use), .stall_clr(b_stall_clr), .en_B1(b_en_B1), .en_M2(b_en_M2),
    .en_H3(b_en_H3), .pc_write(b_pc_write), .ifid_write(b_ifid_write),
    .ifid_flush(b_ifid_flush), .idex_flush(b_idex_flush), .mult_busy(b_mult_busy),
    .mult_done(b_mult_done), .mult_cnt(b_mult_cnt), .stall_cnt(b_stall_cnt)
  );

  assign ctrl   = {en_B1, en_M2, en_H3, pc_write, ifid_write, ifid_flush, idex_flush,
                   mult_busy, mult_done};
  assign b_ctrl = {b_en_B1, b_en_M2, b_en_H3, b_pc_write, b_ifid_write, b_ifid_flush,
                   b_idex_flush, b_mult_busy, b_mult_done};

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    repeat (2) step();
    check("rst_ctrl", 16'(ctrl), 16'(V_IDLE));
    check("rst_mcnt", 16'(mult_cnt), 16'd0);
    check("rst_scnt", stall_cnt, 16'd0);
    check("rst_b_ctrl", 16'(b_ctrl), 16'(V_IDLE));
    check("rst_b_cnts", {b_mult_cnt, b_stall_cnt[7:0]}, 16'd0);
    rst = 1'b0;
    step();
    check("idle_hold", 16'(ctrl), 16'(V_IDLE));

    // Single load-use pulse: one LDSTALL cycle, one stall counted
    load_use = 1'b1;
    step();
    check("ldst_ctrl", 16'(ctrl), 16'(V_LDST));
    load_use = 1'b0;
    step();
    check("ldst_exit", 16'(ctrl), 16'(V_IDLE));
    check("ldst_scnt", stall_cnt, 16'd1);

    // All three events together: branch wins, the rest are dropped
    branch_taken = 1'b1; mult_req = 1'b1; load_use = 1'b1;
    step();
    check("flush_ctrl", 16'(ctrl), 16'(V_FLUSH));
    branch_taken = 1'b0; mult_req = 1'b0; load_use = 1'b0;
    step();
    check("flush_exit", 16'(ctrl), 16'(V_IDLE));
    check("flush_scnt", stall_cnt, 16'd1);
    step();
    check("flush_drop", 16'(ctrl), 16'(V_IDLE));

    // Fresh reset, then a 4-cycle multiply with a branch arriving mid-way
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst2_scnt", stall_cnt, 16'd0);
    mult_req = 1'b1;
    step();
    check("mul1_ctrl", 16'(ctrl), 16'(V_MULT));
    check("mul1_cnt", 16'(mult_cnt), 16'd3);
    mult_req = 1'b0; branch_taken = 1'b1;
    step();
    check("mul2_ctrl", 16'(ctrl), 16'(V_MULT));
    check("mul2_cnt", 16'(mult_cnt), 16'd2);
    step();
    check("mul3_ctrl", 16'(ctrl), 16'(V_MULT));
    check("mul3_cnt", 16'(mult_cnt), 16'd1);
    step();
    check("mul4_ctrl", 16'(ctrl), 16'(V_MDONE));
    check("mul4_cnt", 16'(mult_cnt), 16'd0);
    check("mul4_scnt", stall_cnt, 16'd3);
    branch_taken = 1'b0;
    step();
    check("mul_exit", 16'(ctrl), 16'(V_IDLE));
    check("mul_scnt", stall_cnt, 16'd4);
    check("mul_cnt0", 16'(mult_cnt), 16'd0);

    // Continuous load_use: LDSTALL and IDLE alternate; accepted right after exit
    load_use = 1'b1;
    step();
    check("alt1", 16'(ctrl), 16'(V_LDST));
    step();
    check("alt2", 16'(ctrl), 16'(V_IDLE));
    step();
    check("alt3", 16'(ctrl), 16'(V_LDST));
    step();
    check("alt4", 16'(ctrl), 16'(V_IDLE));
    check("alt_scnt", stall_cnt, 16'd6);
    load_use = 1'b0;

    // Reset in the second multiply cycle aborts it
    mult_req = 1'b1;
    step();
    mult_req = 1'b0;
    check("abort_m1", 16'(ctrl), 16'(V_MULT));
    step();
    check("abort_m2", 16'(mult_cnt), 16'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_ctrl", 16'(ctrl), 16'(V_IDLE));
    check("abort_cnt", 16'(mult_cnt), 16'd0);
    check("abort_scnt", stall_cnt, 16'd0);
    step();
    check("abort_idle", 16'(ctrl), 16'(V_IDLE));

    // Reset has priority over a simultaneous branch
    rst = 1'b1; branch_taken = 1'b1;
    step();
    rst = 1'b0; branch_taken = 1'b0;
    check("rst_prio", 16'(ctrl), 16'(V_IDLE));

    // stall_clr beats the increment of a stall cycle
    load_use = 1'b1;
    step();
    load_use = 1'b0;
    step();
    check("clr_pre", stall_cnt, 16'd1);
    load_use = 1'b1;
    step();
    load_use = 1'b0; stall_clr = 1'b1;
    step();
    stall_clr = 1'b0;
    check("clr_prio", stall_cnt, 16'd0);

    // Saturation on the long-latency instance: 256*255 + 254 = 16'hFFFE
    for (int i = 0; i < 256; i++) begin
      b_mult_req = 1'b1;
      step();
      b_mult_req = 1'b0;
      repeat (255) step();
    end
    check("b_mul_scnt", b_stall_cnt, 16'd65280);
    for (int i = 0; i < 254; i++) begin
      b_load_use = 1'b1;
      step();
      b_load_use = 1'b0;
      step();
    end
    check("sat_fffe", b_stall_cnt, 16'hFFFE);
    b_load_use = 1'b1;
    step();
    b_load_use = 1'b0;
    step();
    check("sat_ffff", b_stall_cnt, 16'hFFFF);
    b_load_use = 1'b1;
    step();
    b_load_use = 1'b0;
    step();
    check("sat_hold", b_stall_cnt, 16'hFFFF);
    b_load_use = 1'b1;
    step();
    b_load_use = 1'b0; b_stall_clr = 1'b1;
    step();
    b_stall_clr = 1'b0;
    check("sat_clr", b_stall_cnt, 16'd0);
    check("sat_idle", 16'(b_ctrl), 16'(V_IDLE));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
